steer_en_cond: RTL and testbench
================================

Name: steer_en_cond

Overview:
Producer side of the steering-enable interface. It converts raw left/right load-cell readings into the qualified condition flags consumed by the steering-enable state machine: sum_gt_min, sum_lt_min, diff_gt_1_4 and diff_gt_15_16. It also owns the 1.3 s rider-settle timer that the state machine clears through clr_tmr and observes through tmr_full. It sits between the A2D interface and steer_en_SM.

Parameters:
LD_W, 12, load-cell sample width (unsigned)
MIN_RIDER_WEIGHT, 12'h200, nominal minimum rider weight, in sum units
HYSTERESIS, 12'h040, half-width of the hysteresis band around MIN_RIDER_WEIGHT
TMR_FULL_CNT, 65_000_000, clk cycles for 1.3 s at 50 MHz
TMR_W, 26, timer counter width

Ports:
clk  in  1  50 MHz clock
rst_n  in  1  asynchronous active-low reset
lft_ld  in  LD_W  left load-cell reading
rght_ld  in  LD_W  right load-cell reading
ld_vld  in  1  one-cycle strobe; lft_ld/rght_ld valid this cycle
clr_tmr  in  1  synchronous timer clear from steer_en_SM
sum_gt_min  out  1  sum > MIN_RIDER_WEIGHT+HYSTERESIS
sum_lt_min  out  1  sum < MIN_RIDER_WEIGHT-HYSTERESIS
diff_gt_1_4  out  1  |lft-rght| > sum/4
diff_gt_15_16  out  1  |lft-rght| > 15/16 sum
tmr_full  out  1  timer has reached TMR_FULL_CNT
cond_vld  out  1  flags reflect at least one real sample

Behaviour:
- Reset: rst_n (asynchronous, active-low) and clk are the only reset and clock.
- Reset values: sum_lt_min=1; sum_gt_min=0; diff_gt_1_4=0; diff_gt_15_16=0; tmr_full=0; cond_vld=0; capture registers=0; timer count=0.
- Stage 1 (capture): on ld_vld, register lft_ld and rght_ld and set an internal stage-1 valid. The captured value holds until the next ld_vld.
- Stage 2 (compare): one cycle after capture, register all four flags from the captured values. The flags change exactly 2 clk cycles after the ld_vld edge.
- Flags hold between samples. cond_vld goes to 1 with the first stage-2 update and stays 1 until reset.
- Back-to-back ld_vld is legal. Each sample propagates independently with 2-cycle latency, with no drop and no stall.
- Arithmetic widths:
  - sum = lft+rght, LD_W+1 bits, no overflow.
  - diff = |lft-rght|, LD_W bits.
  - quarter = sum>>2.
  - f15_16 = sum-(sum>>4), truncating shift.
  - All compares are unsigned and strict.
  - Thresholds are MIN±HYSTERESIS, computed in LD_W+1 bits. MIN-HYST must not underflow; this is an elaboration-time assertion.
- Hysteresis: inside the band (MIN-HYST ≤ sum ≤ MIN+HYST), both sum flags are 0.
- sum=0 gives sum_lt_min=1 and both diff flags 0 (0>0 is false).
- Timer: saturating counter.
  - clr_tmr=1: count←0 next cycle. Clear has priority over increment and over saturation.
  - Otherwise count increments while count<TMR_FULL_CNT, then holds.
  - tmr_full = (count==TMR_FULL_CNT), decoded from the register with no extra latency.
  - After a clr_tmr pulse in cycle N, tmr_full first rises in cycle N+1+TMR_FULL_CNT.
  - clr_tmr held high keeps count=0 and tmr_full=0.
  - The timer free-runs out of reset and is independent of ld_vld.
- Reset mid-operation: all state returns to reset values asynchronously. An in-flight sample is discarded.

Optional Feature:
STEER_FAST_SIM_EN
- Defined: timer terminal count becomes 32768 (replaces TMR_FULL_CNT) so full-chip simulations finish quickly. All other behaviour is unchanged.
- Undefined: terminal count is TMR_FULL_CNT.

Decomposition:
- Package steer_pkg holds:
  - LD_W, MIN_RIDER_WEIGHT, HYSTERESIS, TMR_FULL_CNT, TMR_W
  - the fast-sim count constant
  - a sum_t typedef, logic [LD_W:0]
- Sub-module steer_tmr: saturating timer with clr and full. It takes the terminal count as a parameter; the top level selects that value via the macro.

Test Plan:
- Reset deasserted, no ld_vld -> sum_lt_min=1, other flags 0, cond_vld=0, tmr_full=0.
- ld_vld with lft=300, rght=300 -> 2 cycles later sum_gt_min=1, sum_lt_min=0, both diff flags 0, cond_vld=1.
- lft=250, rght=250 (sum 500, inside band 448..576) -> sum_gt_min=0, sum_lt_min=0.
- lft=400, rght=100 -> diff_gt_1_4=1, diff_gt_15_16=0 (300 ≤ 469). Then lft=500, rght=10 -> diff_gt_15_16=1 (490 > 479).
- clr_tmr pulse -> tmr_full rises exactly TMR_FULL_CNT+1 cycles later (32769 with STEER_FAST_SIM_EN) and holds. A clr_tmr at mid-count drops count to 0 with no tmr_full glitch.
- Back-to-back ld_vld sequence (600/0/440 sums) -> flag updates on consecutive cycles at latency 2. rst_n asserted mid-pipeline -> all outputs go to reset values immediately.

Source files
------------

// File: rtl/steer_pkg.sv
// Shared constants and types for the steering-enable condition block.
package steer_pkg;

   localparam int LD_W = 12;
   localparam int TMR_W = 26;

   localparam logic [LD_W-1:0] MIN_RIDER_WEIGHT = 12'h200;
   localparam logic [LD_W-1:0] HYSTERESIS = 12'h040;

   localparam int unsigned TMR_FULL_CNT = 65_000_000;
   localparam int unsigned FAST_SIM_CNT = 32768;

   typedef logic [LD_W:0] sum_t;

endpackage

// File: rtl/steer_tmr.sv
// Saturating rider-settle timer with synchronous clear.
// Sets full while the count sits at the terminal value TERM.
module steer_tmr #(
   parameter int W = 26,
   parameter int unsigned TERM = 65_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic full
);

   localparam logic [W-1:0] TERM_C = W'(TERM);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (cnt < TERM_C)
         cnt <= cnt + 1'b1;
   end

   assign full = (cnt == TERM_C);

endmodule

// File: rtl/steer_en_cond.sv
// Load-cell condition flags and settle timer for steer_en_SM.
// Define STEER_FAST_SIM_EN to shorten the timer to FAST_SIM_CNT cycles.
module steer_en_cond
   import steer_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [LD_W-1:0] lft_ld,
   input  logic [LD_W-1:0] rght_ld,
   input  logic            ld_vld,
   input  logic            clr_tmr,
   output logic            sum_gt_min,
   output logic            sum_lt_min,
   output logic            diff_gt_1_4,
   output logic            diff_gt_15_16,
   output logic            tmr_full,
   output logic            cond_vld
);

   localparam sum_t THR_HI = sum_t'(MIN_RIDER_WEIGHT) + sum_t'(HYSTERESIS);
   localparam sum_t THR_LO = sum_t'(MIN_RIDER_WEIGHT) - sum_t'(HYSTERESIS);

   generate
      if (HYSTERESIS > MIN_RIDER_WEIGHT) begin : g_thr_chk
         $error("HYSTERESIS exceeds MIN_RIDER_WEIGHT");
      end
   endgenerate

`ifdef STEER_FAST_SIM_EN
   localparam int unsigned TERM = FAST_SIM_CNT;
`else
   localparam int unsigned TERM = TMR_FULL_CNT;
`endif

   logic [LD_W-1:0] lft_q;
   logic [LD_W-1:0] rght_q;
   logic            s1_vld;

   sum_t            sum;
   logic [LD_W-1:0] diff;
   sum_t            quarter;
   sum_t            f15_16;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lft_q  <= '0;
         rght_q <= '0;
         s1_vld <= 1'b0;
      end else begin
         s1_vld <= ld_vld;
         if (ld_vld) begin
            lft_q  <= lft_ld;
            rght_q <= rght_ld;
         end
      end
   end

   always_comb begin
      sum = sum_t'(lft_q) + sum_t'(rght_q);
      diff = (lft_q >= rght_q) ? (lft_q - rght_q)
                               : (rght_q - lft_q);
      quarter = sum >> 2;
      f15_16 = sum - (sum >> 4);
   end

   // Flags only move on a real sample and hold in between.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_gt_min    <= 1'b0;
         sum_lt_min    <= 1'b1;
         diff_gt_1_4   <= 1'b0;
         diff_gt_15_16 <= 1'b0;
         cond_vld      <= 1'b0;
      end else if (s1_vld) begin
         sum_gt_min    <= (sum > THR_HI);
         sum_lt_min    <= (sum < THR_LO);
         diff_gt_1_4   <= (sum_t'(diff) > quarter);
         diff_gt_15_16 <= (sum_t'(diff) > f15_16);
         cond_vld      <= 1'b1;
      end
   end

   steer_tmr #(
      .W    (TMR_W),
      .TERM (TERM)
   ) u_tmr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_tmr),
      .full  (tmr_full)
   );

endmodule

// File: tb/tb_steer_en_cond.sv
// Directed bench for steer_en_cond plus a short-count steer_tmr.
module tb_steer_en_cond;

   logic        clk;
   logic        rst_n;
   logic [11:0] lft_ld;
   logic [11:0] rght_ld;
   logic        ld_vld;
   logic        clr_tmr;
   logic        sum_gt_min;
   logic        sum_lt_min;
   logic        diff_gt_1_4;
   logic        diff_gt_15_16;
   logic        tmr_full;
   logic        cond_vld;

   logic        tclr;
   logic        tfull;

   int n_cmp = 0;
   int n_bad = 0;

   steer_en_cond dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .lft_ld        (lft_ld),
      .rght_ld       (rght_ld),
      .ld_vld        (ld_vld),
      .clr_tmr       (clr_tmr),
      .sum_gt_min    (sum_gt_min),
      .sum_lt_min    (sum_lt_min),
      .diff_gt_1_4   (diff_gt_1_4),
      .diff_gt_15_16 (diff_gt_15_16),
      .tmr_full      (tmr_full),
      .cond_vld      (cond_vld)
   );

   steer_tmr #(
      .W    (8),
      .TERM (20)
   ) u_tmr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (tclr),
      .full  (tfull)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // flags packed as {cond_vld, gt, lt, d14, d1516}
   function automatic logic [4:0] flags();
      return {cond_vld, sum_gt_min, sum_lt_min,
              diff_gt_1_4, diff_gt_15_16};
   endfunction

   task automatic apply(input logic [11:0] l,
                        input logic [11:0] r);
      @(negedge clk);
      lft_ld  = l;
      rght_ld = r;
      ld_vld  = 1'b1;
      @(negedge clk);
      ld_vld  = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst_n   = 1'b0;
      lft_ld  = '0;
      rght_ld = '0;
      ld_vld  = 1'b0;
      clr_tmr = 1'b0;
      tclr    = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      check("reset_flags", 32'(flags()), 32'b0_0100);
      check("reset_tmr", 32'(tmr_full), 32'd0);

      // latency: after the capture edge nothing has moved yet
      @(negedge clk);
      lft_ld = 12'd300; rght_ld = 12'd300; ld_vld = 1'b1;
      @(negedge clk);
      ld_vld = 1'b0;
      check("lat_1cyc", 32'(flags()), 32'b0_0100);
      @(negedge clk);
      check("300_300", 32'(flags()), 32'b1_1000);

      apply(12'd250, 12'd250);
      check("band_500", 32'(flags()), 32'b1_0000);
      apply(12'd400, 12'd100);
      check("diff_1_4", 32'(flags()), 32'b1_0010);
      apply(12'd500, 12'd10);
      check("diff_15_16", 32'(flags()), 32'b1_0011);
      apply(12'd288, 12'd288);
      check("sum_576", 32'(flags()), 32'b1_0000);
      apply(12'd289, 12'd288);
      check("sum_577", 32'(flags()), 32'b1_1000);
      apply(12'd224, 12'd224);
      check("sum_448", 32'(flags()), 32'b1_0000);
      apply(12'd224, 12'd223);
      check("sum_447", 32'(flags()), 32'b1_0100);
      apply(12'd0, 12'd0);
      check("sum_0", 32'(flags()), 32'b1_0100);
      apply(12'd4095, 12'd4095);
      check("sum_max", 32'(flags()), 32'b1_1000);
      apply(12'd4095, 12'd0);
      check("diff_max", 32'(flags()), 32'b1_1011);

      // flags hold with no new sample
      repeat (4) @(negedge clk);
      check("hold", 32'(flags()), 32'b1_1011);

      // back-to-back samples: 600, 0, 440
      lft_ld = 12'd600; rght_ld = 12'd0; ld_vld = 1'b1;
      @(negedge clk);
      lft_ld = 12'd0; rght_ld = 12'd0;
      @(negedge clk);
      lft_ld = 12'd220; rght_ld = 12'd220;
      check("b2b_600", 32'(flags()), 32'b1_1011);
      @(negedge clk);
      ld_vld = 1'b0;
      check("b2b_0", 32'(flags()), 32'b1_0100);
      @(negedge clk);
      check("b2b_440", 32'(flags()), 32'b1_0100);

      // reset with a sample in flight
      apply(12'd300, 12'd300);
      check("pre_rst", 32'(flags()), 32'b1_1000);
      @(negedge clk);
      lft_ld = 12'd0; rght_ld = 12'd0; ld_vld = 1'b1;
      @(negedge clk);
      ld_vld = 1'b0;
      #1 rst_n = 1'b0;
      #1 check("rst_async", 32'(flags()), 32'b0_0100);
      check("rst_tfull", 32'(tmr_full), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_discard", 32'(flags()), 32'b0_0100);

      // short-count timer: clear, then saturate at 20
      tclr = 1'b1;
      @(negedge clk);
      tclr = 1'b0;
      repeat (19) @(negedge clk);
      check("tmr_19", 32'(tfull), 32'd0);
      @(negedge clk);
      check("tmr_20", 32'(tfull), 32'd1);
      repeat (5) @(negedge clk);
      check("tmr_sat", 32'(tfull), 32'd1);

      // clear from saturation, then mid-count clear
      tclr = 1'b1;
      @(negedge clk);
      tclr = 1'b0;
      check("tmr_clr_sat", 32'(tfull), 32'd0);
      repeat (10) @(negedge clk);
      tclr = 1'b1;
      @(negedge clk);
      tclr = 1'b0;
      check("tmr_clr_mid", 32'(tfull), 32'd0);
      repeat (19) @(negedge clk);
      check("tmr_mid_19", 32'(tfull), 32'd0);
      @(negedge clk);
      check("tmr_mid_20", 32'(tfull), 32'd1);

      // clear held high
      tclr = 1'b1;
      repeat (30) @(negedge clk);
      check("tmr_held", 32'(tfull), 32'd0);
      tclr = 1'b0;

      clr_tmr = 1'b1;
      @(negedge clk);
      clr_tmr = 1'b0;
      repeat (50) @(negedge clk);
      check("top_tmr_run", 32'(tmr_full), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
